// File: rtl/mem_access_unit.sv
// mem_access_unit: turns a CPU req/ready/done handshake into setup/strobe/recover memory cycles.
// Optional build macro MAU_POSTED_WRITE_EN: writes report cpu_done one cycle after acceptance.
module mem_access_unit #(
    parameter int unsigned ADDR_W        = 10,
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned SETUP_CYCLES  = 1,
    parameter int unsigned STROBE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_data
);

    localparam int unsigned MAX_CYCLES = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);

`ifdef MAU_POSTED_WRITE_EN
    localparam logic POSTED_WRITE = 1'b1;
`else
    localparam logic POSTED_WRITE = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        RECOVER
    } stateT;

    stateT            state;
    stateT            stateNext;
    logic [CNT_W-1:0] cycleCnt;
    logic [CNT_W-1:0] cycleCntNext;
    logic             opWrite;
    logic             readNext;
    logic             writeNext;
    logic             doneNext;
    logic             readyNext;
    logic             accept;
    logic             capture;

    // Next state plus next values of every registered output; strobes are computed
    // one cycle ahead so the flops drive them glitch-free.
    always_comb begin
        stateNext    = state;
        cycleCntNext = cycleCnt;
        readNext     = 1'b0;
        writeNext    = 1'b0;
        doneNext     = 1'b0;
        readyNext    = 1'b0;
        accept       = 1'b0;
        capture      = 1'b0;

        case (state)
            IDLE: begin
                readyNext = 1'b1;
                if (cpu_req && cpu_ready) begin
                    accept       = 1'b1;
                    readyNext    = 1'b0;
                    stateNext    = SETUP;
                    cycleCntNext = SETUP_LOAD;
                    doneNext     = POSTED_WRITE && cpu_we;
                end
            end

            SETUP: begin
                if (cycleCnt == '0) begin
                    stateNext    = STROBE;
                    cycleCntNext = STROBE_LOAD;
                    readNext     = !opWrite;
                    writeNext    = opWrite;
                end else begin
                    cycleCntNext = cycleCnt - CNT_W'(1);
                end
            end

            STROBE: begin
                if (cycleCnt == '0) begin
                    stateNext = RECOVER;
                    capture   = !opWrite;
                    doneNext  = !(POSTED_WRITE && opWrite);
                end else begin
                    cycleCntNext = cycleCnt - CNT_W'(1);
                    readNext     = !opWrite;
                    writeNext    = opWrite;
                end
            end

            RECOVER: begin
                stateNext = IDLE;
                readyNext = 1'b1;
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // State, counter and output registers; reset drops strobes asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cycleCnt  <= '0;
            opWrite   <= 1'b0;
            cpu_ready <= 1'b0;
            cpu_done  <= 1'b0;
            cpu_rdata <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end else begin
            state     <= stateNext;
            cycleCnt  <= cycleCntNext;
            cpu_ready <= readyNext;
            cpu_done  <= doneNext;
            mem_read  <= readNext;
            mem_write <= writeNext;
            if (accept) begin
                mem_addr  <= cpu_addr;
                mem_wdata <= cpu_wdata;
                opWrite   <= cpu_we;
            end
            if (capture) begin
                cpu_rdata <= mem_data;
            end
        end
    end

    // The memory must never see both strobes, and ready implies the unit is idle.
    assert property (@(posedge clk) disable iff (rst) !(mem_read && mem_write));
    assert property (@(posedge clk) disable iff (rst) cpu_ready |-> (state == IDLE));

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: vector table, directed multi-cycle sequences and a random run
// checked against a transaction-age reference model; dut0 uses defaults, dut1 uses 3/2 timing.
module tb_mem_access_unit;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 16;
`ifdef MAU_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    logic          clk;
    logic          rst0, rst1;
    logic          cpuReq, cpuWe;
    logic [AW-1:0] cpuAddr;
    logic [DW-1:0] cpuWdata;

    logic          ready0, done0, memRead0, memWrite0;
    logic [DW-1:0] rdata0, memWdata0, memData0;
    logic [AW-1:0] memAddr0;
    logic          ready1, done1, memRead1, memWrite1;
    logic [DW-1:0] rdata1, memWdata1, memData1;
    logic [AW-1:0] memAddr1;

    logic [DW-1:0] mem0 [1024];
    logic [DW-1:0] mem1 [1024];
    logic [DW-1:0] refMem [2][1024];

    int nCmp;
    int nBad;
    int cycNo;

    // Reference model state: one outstanding transaction per unit, tracked by its age.
    bit            mBusy [2];
    bit            mReady [2];
    bit            mWe [2];
    int            mAge [2];
    logic [AW-1:0] mAddr [2];
    logic [DW-1:0] mWdata [2];
    logic [DW-1:0] mRdata [2];
    logic [DW-1:0] mPend [2];

    mem_access_unit dut0 (
        .clk(clk), .rst(rst0), .cpu_req(cpuReq), .cpu_we(cpuWe), .cpu_addr(cpuAddr),
        .cpu_wdata(cpuWdata), .cpu_ready(ready0), .cpu_done(done0), .cpu_rdata(rdata0),
        .mem_addr(memAddr0), .mem_wdata(memWdata0), .mem_read(memRead0),
        .mem_write(memWrite0), .mem_data(memData0)
    );

    mem_access_unit #(.SETUP_CYCLES(3), .STROBE_CYCLES(2)) dut1 (
        .clk(clk), .rst(rst1), .cpu_req(cpuReq), .cpu_we(cpuWe), .cpu_addr(cpuAddr),
        .cpu_wdata(cpuWdata), .cpu_ready(ready1), .cpu_done(done1), .cpu_rdata(rdata1),
        .mem_addr(memAddr1), .mem_wdata(memWdata1), .mem_read(memRead1),
        .mem_write(memWrite1), .mem_data(memData1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge-triggered memories on the strobes.
    always @(posedge memRead0)  memData0 = mem0[memAddr0];
    always @(posedge memWrite0) mem0[memAddr0] = memWdata0;
    always @(posedge memRead1)  memData1 = mem1[memAddr1];
    always @(posedge memWrite1) mem1[memAddr1] = memWdata1;

    function automatic logic [DW-1:0] initWord(input int a);
        case (a)
            0:       return 16'h8080;
            1:       return 16'h1111;
            2:       return 16'h2222;
            5:       return 16'h0505;
            default: return 16'(a * 37 + 4096);
        endcase
    endfunction

    function automatic int setupOf(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int strobeOf(input int k);
        return (k == 0) ? 1 : 2;
    endfunction

    function automatic logic [45:0] actOut(input int k);
        if (k == 0) return {ready0, memRead0, memWrite0, done0, memAddr0, memWdata0, rdata0};
        return {ready1, memRead1, memWrite1, done1, memAddr1, memWdata1, rdata1};
    endfunction

    function automatic logic [45:0] modelExp(input int k);
        int s = setupOf(k);
        int t = strobeOf(k);
        int a = mAge[k];
        logic st;
        logic dn;
        st = mBusy[k] && (a > s) && (a <= s + t);
        dn = mBusy[k] && ((POSTED && mWe[k]) ? (a == 1) : (a == s + t + 1));
        return {mReady[k], st && !mWe[k], st && mWe[k], dn, mAddr[k], mWdata[k], mRdata[k]};
    endfunction

    task automatic modelReset(input int k);
        mBusy[k] = 0; mReady[k] = 0; mWe[k] = 0; mAge[k] = 0;
        mAddr[k] = '0; mWdata[k] = '0; mRdata[k] = '0; mPend[k] = '0;
    endtask

    // Advance the model across one rising edge using the inputs presented now.
    task automatic modelEdge(input int k);
        int last = setupOf(k) + strobeOf(k) + 1;
        if (mBusy[k]) begin
            if (mAge[k] == last) begin
                mBusy[k]  = 0;
                mReady[k] = 1;
            end else begin
                mAge[k]++;
                if (mAge[k] == last && !mWe[k]) mRdata[k] = mPend[k];
            end
        end else if (mReady[k] && cpuReq) begin
            mBusy[k]  = 1;
            mReady[k] = 0;
            mAge[k]   = 1;
            mWe[k]    = cpuWe;
            mAddr[k]  = cpuAddr;
            mWdata[k] = cpuWdata;
            if (cpuWe) refMem[k][cpuAddr] = cpuWdata;
            else       mPend[k] = refMem[k][cpuAddr];
        end else begin
            mReady[k] = 1;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        modelEdge(0);
        modelEdge(1);
        @(posedge clk);
        #1;
        cycNo++;
        chk($sformatf("model dut0 cyc%0d", cycNo), 64'(actOut(0)), 64'(modelExp(0)));
        chk($sformatf("model dut1 cyc%0d", cycNo), 64'(actOut(1)), 64'(modelExp(1)));
    endtask

    task automatic setIn(input logic req, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata);
        cpuReq = req; cpuWe = we; cpuAddr = addr; cpuWdata = wdata;
    endtask

    typedef struct {
        logic          req;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          eReady;
        logic          eRead;
        logic          eWrite;
        logic          eDone;
        logic [AW-1:0] eAddr;
        logic [DW-1:0] eWdata;
        logic [DW-1:0] eRdata;
    } vecT;

    function automatic vecT mkVec(input logic req, input logic we, input logic [AW-1:0] addr,
                                  input logic [DW-1:0] wdata, input logic rdy, input logic rd,
                                  input logic wr, input logic dn, input logic [AW-1:0] ea,
                                  input logic [DW-1:0] ew, input logic [DW-1:0] er);
        vecT v;
        v.req = req; v.we = we; v.addr = addr; v.wdata = wdata;
        v.eReady = rdy; v.eRead = rd; v.eWrite = wr; v.eDone = dn;
        v.eAddr = ea; v.eWdata = ew; v.eRdata = er;
        return v;
    endfunction

    vecT vecs [20];

    initial begin
        logic [45:0] expV;
        nCmp = 0; nBad = 0; cycNo = 0;
        setIn(0, 0, '0, '0);
        rst0 = 1; rst1 = 1;
        for (int i = 0; i < 1024; i++) begin
            mem0[i] = initWord(i);
            mem1[i] = initWord(i);
            refMem[0][i] = initWord(i);
            refMem[1][i] = initWord(i);
        end
        modelReset(0);
        modelReset(1);

        // Per-cycle vectors for dut0: read 0, write/read 1F5, back-to-back reads 1 and 2.
        vecs[0]  = mkVec(1, 0, 10'h000, 16'h0000, 0, 0, 0, 0, 10'h000, 16'h0000, 16'h0000);
        vecs[1]  = mkVec(0, 0, 10'h000, 16'h0000, 0, 1, 0, 0, 10'h000, 16'h0000, 16'h0000);
        vecs[2]  = mkVec(0, 0, 10'h000, 16'h0000, 0, 0, 0, 1, 10'h000, 16'h0000, 16'h8080);
        vecs[3]  = mkVec(0, 0, 10'h000, 16'h0000, 1, 0, 0, 0, 10'h000, 16'h0000, 16'h8080);
        vecs[4]  = mkVec(1, 1, 10'h1F5, 16'hABCD, 0, 0, 0, POSTED, 10'h1F5, 16'hABCD, 16'h8080);
        vecs[5]  = mkVec(0, 1, 10'h1F5, 16'hABCD, 0, 0, 1, 0, 10'h1F5, 16'hABCD, 16'h8080);
        vecs[6]  = mkVec(0, 0, 10'h000, 16'h0000, 0, 0, 0, !POSTED, 10'h1F5, 16'hABCD, 16'h8080);
        vecs[7]  = mkVec(0, 0, 10'h000, 16'h0000, 1, 0, 0, 0, 10'h1F5, 16'hABCD, 16'h8080);
        vecs[8]  = mkVec(1, 0, 10'h1F5, 16'h0000, 0, 0, 0, 0, 10'h1F5, 16'h0000, 16'h8080);
        vecs[9]  = mkVec(0, 0, 10'h000, 16'h0000, 0, 1, 0, 0, 10'h1F5, 16'h0000, 16'h8080);
        vecs[10] = mkVec(0, 0, 10'h000, 16'h0000, 0, 0, 0, 1, 10'h1F5, 16'h0000, 16'hABCD);
        vecs[11] = mkVec(0, 0, 10'h000, 16'h0000, 1, 0, 0, 0, 10'h1F5, 16'h0000, 16'hABCD);
        vecs[12] = mkVec(1, 0, 10'h001, 16'h0000, 0, 0, 0, 0, 10'h001, 16'h0000, 16'hABCD);
        vecs[13] = mkVec(1, 0, 10'h002, 16'h0000, 0, 1, 0, 0, 10'h001, 16'h0000, 16'hABCD);
        vecs[14] = mkVec(1, 0, 10'h002, 16'h0000, 0, 0, 0, 1, 10'h001, 16'h0000, 16'h1111);
        vecs[15] = mkVec(1, 0, 10'h002, 16'h0000, 1, 0, 0, 0, 10'h001, 16'h0000, 16'h1111);
        vecs[16] = mkVec(1, 0, 10'h002, 16'h0000, 0, 0, 0, 0, 10'h002, 16'h0000, 16'h1111);
        vecs[17] = mkVec(0, 0, 10'h000, 16'h0000, 0, 1, 0, 0, 10'h002, 16'h0000, 16'h1111);
        vecs[18] = mkVec(0, 0, 10'h000, 16'h0000, 0, 0, 0, 1, 10'h002, 16'h0000, 16'h2222);
        vecs[19] = mkVec(0, 0, 10'h000, 16'h0000, 1, 0, 0, 0, 10'h002, 16'h0000, 16'h2222);

        // Reset state, sampled while reset is held.
        #12;
        chk("reset dut0", 64'(actOut(0)), 64'd0);
        chk("reset dut1", 64'(actOut(1)), 64'd0);
        #10;
        rst0 = 0; rst1 = 0;
        cycle();
        chk("ready after reset", 64'(ready0), 64'd1);

        for (int i = 0; i < 20; i++) begin
            setIn(vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            cycle();
            expV = {vecs[i].eReady, vecs[i].eRead, vecs[i].eWrite, vecs[i].eDone,
                    vecs[i].eAddr, vecs[i].eWdata, vecs[i].eRdata};
            chk($sformatf("vec%0d", i), 64'(actOut(0)), 64'(expV));
        end
        setIn(0, 0, '0, '0);
        for (int i = 0; i < 10; i++) cycle();

        // Stretched timing on dut1: read of addr 5.
        setIn(1, 0, 10'd5, 16'h0000);
        for (int c = 1; c <= 7; c++) begin
            cycle();
            if (c == 1) setIn(0, 0, '0, '0);
            chk($sformatf("dut1 read c%0d", c), 64'(memRead1), 64'(c == 4 || c == 5));
            chk($sformatf("dut1 done c%0d", c), 64'(done1), 64'(c == 6));
            if (c <= 6) chk($sformatf("dut1 addr c%0d", c), 64'(memAddr1), 64'd5);
            if (c == 6) chk("dut1 rdata", 64'(rdata1), 64'h0505);
            if (c == 7) chk("dut1 ready", 64'(ready1), 64'd1);
        end
        for (int i = 0; i < 4; i++) cycle();

        // Reset during the write strobe of dut0.
        setIn(1, 1, 10'd3, 16'h5A5A);
        cycle();
        setIn(0, 0, '0, '0);
        cycle();
        chk("rst test strobe", 64'(memWrite0), 64'd1);
        #2;
        rst0 = 1;
        modelReset(0);
        #1;
        chk("rst async outputs", 64'(actOut(0)), 64'd0);
        #2;
        rst0 = 0;
        chk("rst ready low", 64'(ready0), 64'd0);
        cycle();
        chk("rst ready after", 64'(ready0), 64'd1);
        chk("rst no done", 64'(done0), 64'd0);
        for (int i = 0; i < 8; i++) cycle();

        // Write to addr 7 with a read of addr 8 waiting behind it.
        setIn(1, 1, 10'd7, 16'h7777);
        cycle();
        chk("wr7 done c1", 64'(done0), 64'(POSTED));
        chk("wr7 ready c1", 64'(ready0), 64'd0);
        setIn(1, 0, 10'd8, 16'h0000);
        cycle();
        chk("wr7 write c2", 64'(memWrite0), 64'd1);
        chk("wr7 done c2", 64'(done0), 64'd0);
        cycle();
        chk("wr7 done c3", 64'(done0), 64'(!POSTED));
        cycle();
        chk("wr7 ready c4", 64'(ready0), 64'd1);
        chk("wr7 addr c4", 64'(memAddr0), 64'd7);
        cycle();
        chk("wr7 addr c5", 64'(memAddr0), 64'd8);
        setIn(0, 0, '0, '0);
        for (int i = 0; i < 8; i++) cycle();

        // Random traffic on a small address window to exercise read-after-write.
        for (int i = 0; i < 600; i++) begin
            setIn($urandom_range(0, 99) < 60, 1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, 15)), DW'($urandom));
            cycle();
        end
        setIn(0, 0, '0, '0);
        for (int i = 0; i < 8; i++) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
